// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: n/a (constants, enum and pure functions only).
// Backpressure: n/a.
// Contents: funct3 encodings, idle memory control code, FSM state enum,
//   access-size and alignment helpers.
package lsu_pkg;

  // RISC-V load/store funct3 encodings; the memory's dm_ctrl uses the same codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // dm_ctrl code meaning "no read or write action" in the memory.
  localparam logic [2:0] DM_CTRL_IDLE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    STB,
    RESP
  } lsu_state_t;

  // Access size in bytes from funct3[1:0]; an illegal code reports 4 but is
  // rejected separately by f3_legal.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    is_misaligned = ((size == 3'd4) && (addr_lo != 2'b00)) ||
                    ((size == 3'd2) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
// Latency: n/a (signal bundle only).
// Backpressure: req_valid/req_ready for requests, rsp_valid/rsp_ready for responses.
// master: the core (drives request fields and rsp_ready).
// slave:  the load/store unit (drives req_ready and response fields).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Load result formatter: shifts a two-word window down by the byte offset,
//   keeps the low 1/2/4 bytes and sign/zero extends them per funct3.
// Latency: combinational. Backpressure: none.
// Ports: window = {word1, word0}, offset = addr[1:0], funct3 = load type, data = result.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sign_ext;

  always_comb begin
    shifted  = 32'(window >> {offset, 3'b000});
    // funct3[2] marks the unsigned loads (BU/HU).
    sign_ext = ~funct3[2];
    case (size_of(funct3))
      3'd1:    data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      3'd2:    data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a byte-addressed data memory with a
//   combinational read port; splits misaligned accesses, faults illegal ones.
// Latency (accept -> rsp_valid): aligned 2, misaligned load 3, misaligned
//   store of n bytes n+1, fault 1. Backpressure: one request in flight,
//   req_ready only in IDLE; the response is held until rsp_ready.
// Ports: clk, rst (sync, active high); core = request/response handshake
//   (slave side); dm_* = memory address/write_data/write_enable/dm_ctrl
//   outputs and the memory's read_data input.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 256,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave core,
  output logic [31:0]      dm_address,
  output logic [31:0]      dm_write_data,
  output logic             dm_write_enable,
  output logic [2:0]       dm_ctrl,
  input  logic [31:0]      dm_read_data
);

  lsu_state_t  state;

  // Latched request.
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mis_q;
  logic [31:0] word0_q;
  logic [1:0]  byte_idx;

  // Request decode, evaluated against the live request in IDLE.
  logic        accept;
  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_mis;
  logic        req_fault;

  always_comb begin
    accept    = core.req_valid && core.req_ready;
    req_size  = size_of(core.req_funct3);
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    req_last  = {1'b0, core.req_addr} + {30'd0, req_size} - 33'd1;
    req_mis   = is_misaligned(core.req_addr[1:0], req_size);
    req_fault = !f3_legal(core.req_funct3) ||
                (core.req_we && core.req_funct3[2]) ||
                (req_last >= 33'(MEM_BYTES)) ||
                (req_mis && !SPLIT_MISALIGNED);
  end

  // Split-store byte walk.
  logic [1:0] byte_nxt;
  logic [1:0] byte_last;

  assign byte_nxt  = byte_idx + 2'd1;
  assign byte_last = 2'(size_of(f3_q) - 3'd1);

  // Aligned loads pass the memory's already-formatted result through the
  // formatter at offset 0 (a no-op for correctly extended data); the second
  // word of a split load supplies the upper half of the window.
  logic [63:0] align_window;
  logic [1:0]  align_offset;
  logic [31:0] align_data;

  always_comb begin
    if (state == ACC1) begin
      align_window = {dm_read_data, word0_q};
      align_offset = addr_q[1:0];
    end else begin
      align_window = {32'h0, dm_read_data};
      align_offset = 2'b00;
    end
  end

  lsu_align u_align (
    .window (align_window),
    .offset (align_offset),
    .funct3 (f3_q),
    .data   (align_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      core.req_ready  <= 1'b1;
      core.rsp_valid  <= 1'b0;
      core.rsp_rdata  <= 32'h0;
      core.rsp_err    <= 1'b0;
      dm_address      <= 32'h0;
      dm_write_data   <= 32'h0;
      dm_write_enable <= 1'b0;
      dm_ctrl         <= DM_CTRL_IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      mis_q           <= 1'b0;
      word0_q         <= 32'h0;
      byte_idx        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q           <= core.req_we;
            f3_q           <= core.req_funct3;
            addr_q         <= core.req_addr;
            wdata_q        <= core.req_wdata;
            mis_q          <= req_mis;
            byte_idx       <= 2'd0;
            core.req_ready <= 1'b0;
            core.rsp_rdata <= 32'h0;
            core.rsp_err   <= req_fault;
            if (req_fault) begin
              // Memory outputs stay idle: a fault never reaches the memory.
              state          <= RESP;
              core.rsp_valid <= 1'b1;
            end else if (req_mis && core.req_we) begin
              state           <= STB;
              dm_address      <= core.req_addr;
              dm_write_data   <= core.req_wdata;
              dm_write_enable <= 1'b1;
              dm_ctrl         <= F3_B;
            end else if (req_mis) begin
              state         <= ACC0;
              dm_address    <= {core.req_addr[31:2], 2'b00};
              dm_write_data <= 32'h0;
              dm_ctrl       <= F3_W;
            end else begin
              state           <= ACC0;
              dm_address      <= core.req_addr;
              dm_write_data   <= core.req_we ? core.req_wdata : 32'h0;
              dm_write_enable <= core.req_we;
              dm_ctrl         <= core.req_funct3;
            end
          end
        end

        ACC0: begin
          if (mis_q) begin
            // Split load: hold the first word, fetch the following one.
            state      <= ACC1;
            word0_q    <= dm_read_data;
            dm_address <= {addr_q[31:2], 2'b00} + 32'd4;
          end else begin
            state           <= RESP;
            core.rsp_valid  <= 1'b1;
            core.rsp_rdata  <= we_q ? 32'h0 : align_data;
            dm_write_enable <= 1'b0;
            dm_ctrl         <= DM_CTRL_IDLE;
          end
        end

        ACC1: begin
          state          <= RESP;
          core.rsp_valid <= 1'b1;
          core.rsp_rdata <= align_data;
          dm_ctrl        <= DM_CTRL_IDLE;
        end

        STB: begin
          // One byte per cycle; a store crossing a word boundary just keeps
          // incrementing the byte address.
          if (byte_idx == byte_last) begin
            state           <= RESP;
            core.rsp_valid  <= 1'b1;
            dm_write_enable <= 1'b0;
            dm_ctrl         <= DM_CTRL_IDLE;
          end else begin
            byte_idx      <= byte_nxt;
            dm_address    <= addr_q + {30'd0, byte_nxt};
            dm_write_data <= wdata_q >> {byte_nxt, 3'b000};
          end
        end

        RESP: begin
          // The completing handshake cycle never doubles as an accept cycle:
          // req_ready only rises on the following cycle.
          if (core.rsp_ready) begin
            state          <= IDLE;
            core.rsp_valid <= 1'b0;
            core.req_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of the data memory. It accepts load/store requests from the core over a valid/ready handshake and drives the memory's address, write_data, write_enable and dm_ctrl inputs. It consumes the memory's combinational read_data.
- Aligned accesses pass through natively in one memory cycle.
- Misaligned accesses are split: loads become two aligned word reads that are merged; stores become a sequence of byte stores.
- Out-of-range and illegal requests return an error without touching memory.

Parameters:
MEM_BYTES, 256, size of the data memory in bytes; any access whose last byte is >= MEM_BYTES faults.
SPLIT_MISALIGNED, 1, 1 = split misaligned accesses; 0 = misaligned requests fault.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load result, sign/zero extended; 0 for stores and errors
rsp_err  out  1  request faulted; no memory side effect
dm_address  out  32  to memory address
dm_write_data  out  32  to memory write_data
dm_write_enable  out  1  to memory write_enable
dm_ctrl  out  3  to memory dm_ctrl
dm_read_data  in  32  from memory read_data (combinational)

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_address=0, dm_write_data=0, dm_write_enable=0, dm_ctrl=3'b111 (idle; no read or write action in memory). All outputs are registered.
- Acceptance: a request is accepted on cycle T when req_valid && req_ready. The request is latched, and size = 1/2/4 bytes from funct3[1:0].
- Faults, checked at acceptance:
  - funct3 in {011, 110, 111}.
  - Store with funct3[2]=1.
  - addr + size - 1 >= MEM_BYTES (including 32-bit overflow).
  - Misaligned access with SPLIT_MISALIGNED=0.
  - Result: go to RESP at T+1 with rsp_err=1, rsp_rdata=0; dm_write_enable stays 0 throughout.
- FSM states: IDLE, ACC0, ACC1, STB, RESP.
  - IDLE: on accept -> ACC0 (aligned, or misaligned load), STB (misaligned store), or RESP (fault).
  - ACC0 (cycle T+1): dm_address = addr. For an aligned access, dm_ctrl = funct3. For a misaligned load, dm_ctrl=010 and dm_address = addr & ~3.
    - Aligned store: dm_write_enable=1, dm_write_data=wdata.
    - Aligned load: capture dm_read_data into rsp_rdata.
    - Next state: RESP (aligned) or ACC1 (misaligned load, capturing word0).
  - ACC1 (T+2): dm_address = (addr & ~3) + 4, dm_ctrl=010. Capture word1 and form the 64-bit window {word1, word0} >> (8*addr[1:0]). Take the low size bytes and extend per funct3[2]. Next state: RESP.
  - STB: one byte store per cycle. dm_ctrl=000, dm_write_enable=1, dm_address = addr + i, dm_write_data = wdata >> (8*i), for i = 0..size-1. Advance to RESP after the last byte. A store that crosses a word boundary simply continues into the next word.
  - RESP: rsp_valid=1 and outputs stable; dm_write_enable=0, dm_ctrl=111. When rsp_ready is high -> IDLE with req_ready=1 on the next cycle. rsp_valid and rsp_ready asserted in the same cycle complete the response; there is no back-to-back accept in that cycle.
- Latency from acceptance to rsp_valid:
  - Aligned: T+2.
  - Misaligned load: T+3.
  - Misaligned store of n bytes: T+n+1.
  - Fault: T+1.
- Aligned half means addr[0]=0. Aligned word means addr[1:0]=0.
- Reset mid-operation: the FSM returns to IDLE next cycle. Remaining bytes of a split store are not written (partial store is acceptable and documented). Any pending response is dropped.
- rsp_valid is never deasserted without rsp_ready. A req_valid seen while not in IDLE is ignored, with req_ready=0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - DM_CTRL_IDLE = 3'b111.
  - State enum lsu_state_t.
  - Function size_of(funct3).
- Sub-module lsu_align: combinational window merge plus sign/zero extension of {word1, word0}, offset and funct3; shared by ACC0 and ACC1.

Test Plan:
Initial memory: word0=0x12345678, word1=0xABCDEF00, word2=0x00000064, word3=0xFFFFFFFF, word4=0x000000FF.
1. Aligned LW at 0x04 -> rsp_rdata=0xABCDEF00, rsp_err=0, rsp_valid at T+2, exactly one memory access cycle.
2. Misaligned LW at 0x02 -> 0xEF001234 at T+3. LH at 0x0F -> 0xFFFFFFFF; LHU at 0x0F -> 0x0000FFFF.
3. Misaligned SW 0xAABBCCDD at 0x05 -> four SB cycles to 0x05..0x08; word1=0xBBCCDD00, word2=0x000000AA, rsp at T+5. LW at 0x08 then returns 0x000000AA.
4. LW at 0xFE, LB at 0x100, store with funct3=100 -> rsp_err=1 at T+1, dm_write_enable never asserted, memory unchanged.
5. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; a new req_valid is not accepted until the cycle after the handshake.
6. Assert rst on the second SB of a misaligned SW at 0x03 -> byte 0x03 is written, byte 0x04 onward is not. After reset, all outputs return to reset values and the unit accepts the next request.
